// File: rtl/sm3_pkg.sv
// sm3_pkg: shared types and bus-width constants for the SM3 message front end.
package sm3_pkg;
`ifdef SM3_INPT_DW_32
    localparam int SM3_INPT_DW = 32;
`else
    localparam int SM3_INPT_DW = 64;
`endif
    localparam int SM3_INPT_BYTE_W = SM3_INPT_DW / 8;
    typedef enum logic [1:0] {IDLE, XFER, WAIT_DONE} sm3_arb_st_e;
endpackage

// File: rtl/sm3_msg_arb_if.sv
// sm3_msg_arb_if: requester-side and padding-core-side signals of the message arbiter.
interface sm3_msg_arb_if import sm3_pkg::*; #(
    parameter int REQ_NUM = 4,
    parameter int INPT_DW = SM3_INPT_DW,
    parameter int ID_W    = $clog2(REQ_NUM)
);
    logic [REQ_NUM-1:0]           req_vld;
    logic [REQ_NUM-1:0]           req_lst;
    logic [REQ_NUM*INPT_DW-1:0]   req_d;
    logic [REQ_NUM*INPT_DW/8-1:0] req_vld_byte;
    logic [REQ_NUM-1:0]           req_rdy;
    logic [INPT_DW-1:0]           msg_inpt_d;
    logic [INPT_DW/8-1:0]         msg_inpt_vld_byte;
    logic                         msg_inpt_vld;
    logic                         msg_inpt_lst;
    logic                         msg_inpt_rdy;
    logic                         hash_done;
    logic                         done_vld;
    logic [ID_W-1:0]              done_id;
    logic                         busy;
    logic                         err_spur_done;
    modport slave (
        input  req_vld, req_lst, req_d, req_vld_byte, msg_inpt_rdy, hash_done,
        output req_rdy, msg_inpt_d, msg_inpt_vld_byte, msg_inpt_vld, msg_inpt_lst,
               done_vld, done_id, busy, err_spur_done
    );
    modport master (
        output req_vld, req_lst, req_d, req_vld_byte, msg_inpt_rdy, hash_done,
        input  req_rdy, msg_inpt_d, msg_inpt_vld_byte, msg_inpt_vld, msg_inpt_lst,
               done_vld, done_id, busy, err_spur_done
    );
endinterface

// File: rtl/sm3_rr_pick.sv
// sm3_rr_pick: combinational round-robin picker, search starts just after last_id and wraps.
module sm3_rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last_id,
    output logic            any,
    output logic [ID_W-1:0] pick_id
);
    logic [ID_W-1:0] w_idx;
    assign any = |req;
    // Walk farthest-to-nearest so the nearest requester after last_id overwrites the rest.
    always_comb begin
        pick_id = '0;
        w_idx   = '0;
        for (int k = N; k >= 1; k--) begin
            w_idx = ID_W'((int'(last_id) + k) % N);
            if (req[w_idx]) pick_id = w_idx;
        end
    end
endmodule

// File: rtl/sm3_msg_arb.sv
// sm3_msg_arb: grants the SM3 padding-core input to one requester per message and tags its digest.
module sm3_msg_arb import sm3_pkg::*; #(
    parameter int REQ_NUM = 4,
    parameter int INPT_DW = SM3_INPT_DW,
    parameter int ID_W    = $clog2(REQ_NUM)
) (
    input  logic           clk,
    input  logic           rst,
    sm3_msg_arb_if.slave   bus
);
    localparam int BW = INPT_DW / 8;
    sm3_arb_st_e     r_st, w_nxt;
    logic [ID_W-1:0] r_gnt_id, r_last_id, r_done_id, w_pick;
    logic            r_done_vld, r_err, w_any, w_xfer, w_wait, w_acc, w_hd_ok;

    sm3_rr_pick #(.N(REQ_NUM), .ID_W(ID_W)) u_pick (
        .req     (bus.req_vld),
        .last_id (r_last_id),
        .any     (w_any),
        .pick_id (w_pick)
    );

    assign w_xfer  = r_st == XFER;
    assign w_wait  = r_st == WAIT_DONE;
    assign w_acc   = w_xfer & bus.req_vld[r_gnt_id] & bus.msg_inpt_rdy;
    assign w_hd_ok = w_wait & bus.hash_done;

    always_comb begin
        w_nxt = r_st;
        w_nxt = (r_st == IDLE && w_any)          ? XFER      :
                (w_acc && bus.req_lst[r_gnt_id]) ? WAIT_DONE :
                w_hd_ok                          ? IDLE      : r_st;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_st       <= IDLE;
            r_gnt_id   <= '0;
            r_last_id  <= ID_W'(REQ_NUM - 1);
            r_done_vld <= 1'b0;
            r_done_id  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_st       <= w_nxt;
            r_done_vld <= w_hd_ok;
            r_err      <= r_err | (bus.hash_done & ~w_wait);
            if (r_st == IDLE && w_any) r_gnt_id <= w_pick;
            if (w_hd_ok) r_last_id <= r_gnt_id;
            if (w_hd_ok) r_done_id <= r_gnt_id;
        end
    end

    // Only the owner sees ready, and only while its message is streaming.
    assign bus.req_rdy           = w_xfer ? REQ_NUM'(bus.msg_inpt_rdy) << r_gnt_id : '0;
    assign bus.msg_inpt_d        = w_xfer ? bus.req_d[r_gnt_id*INPT_DW +: INPT_DW] : '0;
    assign bus.msg_inpt_vld_byte = w_xfer ? bus.req_vld_byte[r_gnt_id*BW +: BW] : '0;
    assign bus.msg_inpt_vld      = w_xfer & bus.req_vld[r_gnt_id];
    assign bus.msg_inpt_lst      = w_xfer & bus.req_lst[r_gnt_id];
    assign bus.done_vld          = r_done_vld;
    assign bus.done_id           = r_done_id;
    assign bus.busy              = r_st != IDLE;
    assign bus.err_spur_done     = r_err;
endmodule

// File: tb/tb_sm3_msg_arb.sv
// tb_sm3_msg_arb: random multi-requester traffic checked against a message-level arbiter model.
module tb_sm3_msg_arb;
    localparam int N  = 4;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sm3_msg_arb_if #(.REQ_NUM(N), .INPT_DW(DW)) bus ();
    sm3_msg_arb #(.REQ_NUM(N), .INPT_DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tot = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // requester drivers: rem = words left in the current message
    int          rem[N], gap[N], d_words[N], m_words[N], m_msgs[N];
    logic [63:0] cd[N];
    logic [7:0]  cb[N];

    // model of the arbiter at message level: owner -1 means nobody holds the pipeline
    int m_own, m_last, m_hd_cnt, m_done_id;
    bit m_wait, m_err, m_done;

    task automatic new_word(input int i);
        cd[i] = {$urandom, $urandom};
        cb[i] = (rem[i] == 1) ? (8'hFF << $urandom_range(0, 7)) : 8'hFF;
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            bus.req_vld[i]              = rem[i] > 0;
            bus.req_lst[i]              = rem[i] == 1;
            bus.req_d[i*DW +: DW]       = cd[i];
            bus.req_vld_byte[i*8 +: 8]  = cb[i];
        end
    endtask

    task automatic model_reset();
        m_own = -1; m_last = N - 1; m_wait = 0; m_err = 0; m_done = 0; m_done_id = 0; m_hd_cnt = 0;
    endtask

    initial begin
        logic [N-1:0] e_rdy;
        bit           xf, acc, hd;
        for (int i = 0; i < N; i++) begin
            rem[i] = 0; gap[i] = 0; cd[i] = '0; cb[i] = '0;
            d_words[i] = 0; m_words[i] = 0; m_msgs[i] = 0;
        end
        model_reset();
        drive_reqs();
        bus.msg_inpt_rdy = 1'b0;
        bus.hash_done    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_vld", 64'(bus.msg_inpt_vld), 64'd0);
        chk("rst_d", bus.msg_inpt_d, 64'd0);
        chk("rst_rdy", 64'(bus.req_rdy), 64'd0);
        chk("rst_done", 64'(bus.done_vld), 64'd0);
        chk("rst_done_id", 64'(bus.done_id), 64'd0);
        chk("rst_err", 64'(bus.err_spur_done), 64'd0);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = (c < 1) || (c % 500 == 499);
            for (int i = 0; i < N; i++) begin
                if (rem[i] == 0) begin
                    if (gap[i] > 0) gap[i]--;
                    else begin
                        rem[i] = $urandom_range(1, 5);
                        new_word(i);
                    end
                end
            end
            drive_reqs();
            bus.msg_inpt_rdy = 1'($urandom_range(0, 1));
            bus.hash_done    = (m_hd_cnt == 1) || (m_hd_cnt == 0 && $urandom_range(0, 149) == 0);
            #1;
            xf    = (m_own >= 0) && !m_wait;
            e_rdy = xf ? (N'(bus.msg_inpt_rdy) << m_own) : '0;
            chk("req_rdy", 64'(bus.req_rdy), 64'(e_rdy));
            chk("msg_d", bus.msg_inpt_d, xf ? cd[m_own] : 64'd0);
            chk("msg_be", 64'(bus.msg_inpt_vld_byte), xf ? 64'(cb[m_own]) : 64'd0);
            chk("msg_vld", 64'(bus.msg_inpt_vld), xf ? 64'(rem[m_own] > 0) : 64'd0);
            chk("msg_lst", 64'(bus.msg_inpt_lst), xf ? 64'(rem[m_own] == 1) : 64'd0);
            chk("busy", 64'(bus.busy), 64'(m_own >= 0));
            chk("done_vld", 64'(bus.done_vld), 64'(m_done));
            if (m_done) chk("done_id", 64'(bus.done_id), 64'(m_done_id));
            chk("err", 64'(bus.err_spur_done), 64'(m_err));
            acc = xf && rem[m_own] > 0 && bus.msg_inpt_rdy;
            hd  = bus.hash_done;
            m_done = 0;
            if (m_hd_cnt > 0) m_hd_cnt--;
            if (rst) model_reset();
            else if (hd && m_wait) begin
                m_done = 1; m_done_id = m_own; m_last = m_own; m_own = -1; m_wait = 0;
            end else begin
                if (hd) m_err = 1;
                if (m_own < 0) begin
                    for (int k = 1; k <= N; k++) begin
                        if (m_own < 0 && rem[(m_last + k) % N] > 0) m_own = (m_last + k) % N;
                    end
                end else if (acc) begin
                    m_words[m_own]++;
                    if (rem[m_own] == 1) begin
                        m_wait = 1; m_msgs[m_own]++; m_hd_cnt = $urandom_range(1, 3);
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!rst && bus.req_vld[i] && bus.req_rdy[i]) begin
                    d_words[i]++;
                    rem[i]--;
                    if (rem[i] > 0) new_word(i);
                    else gap[i] = $urandom_range(0, 6);
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            chk($sformatf("words%0d", i), 64'(d_words[i]), 64'(m_words[i]));
            chk($sformatf("progress%0d", i), 64'(m_msgs[i] > 0), 64'd1);
        end
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule

// File: doc/sm3_msg_arb.md
# sm3_msg_arb

Round-robin message arbiter that shares one SM3 padding/expansion/compression pipeline between `REQ_NUM` independent message sources. It grants the pipeline's message input bus to one requester for a whole message, from first word through `lst`, and holds ownership until the pipeline reports the digest for that message. It then tags the completion with the owner's ID. The block sits directly in front of the padding core's `msg_inpt_*` bus.

## Interface
Parameters:
- `REQ_NUM`, default 4: number of requesters, legal range 2..8.
- `INPT_DW`, default 64: message bus width, 32 or 64. Must match the `SM3_INPT_DW_32` / `SM3_INPT_DW_64` build configuration.
- `ID_W`, default `$clog2(REQ_NUM)`: width of the requester ID. Derived; do not override.

Ports:
- `clk`, in, 1: the single clock. All logic is on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `req_vld`, in, `REQ_NUM`: per-requester word valid.
- `req_lst`, in, `REQ_NUM`: per-requester last-word flag.
- `req_d`, in, `REQ_NUM*INPT_DW`: per-requester data. Requester i occupies slice `[i*INPT_DW +: INPT_DW]`; big-endian bytes, MSB first.
- `req_vld_byte`, in, `REQ_NUM*INPT_DW/8`: per-requester byte-valid mask. Left-aligned, MSB = first byte.
- `req_rdy`, out, `REQ_NUM`: per-requester ready.
- `msg_inpt_d`, out, `INPT_DW`: data to the padding core.
- `msg_inpt_vld_byte`, out, `INPT_DW/8`: byte-valid mask to the padding core.
- `msg_inpt_vld`, out, 1: word valid to the padding core.
- `msg_inpt_lst`, out, 1: last-word flag to the padding core.
- `msg_inpt_rdy`, in, 1: the padding core accepts a word in a cycle where `vld & rdy`.
- `hash_done`, in, 1: single-cycle pulse when the digest of the current message is valid.
- `done_vld`, out, 1: registered pulse one cycle after an accepted `hash_done`.
- `done_id`, out, `ID_W`: ID of the message owner; valid while `done_vld`.
- `busy`, out, 1: high in every state except IDLE.
- `err_spur_done`, out, 1: sticky flag, set on `hash_done` outside WAIT_DONE.

## Operation
State machine with states IDLE, XFER and WAIT_DONE.

IDLE:
- If any `req_vld` is high, the round-robin pick registers `gnt_id` and the FSM goes to XFER.
- No word is forwarded in this cycle, and all `req_rdy` are 0.

Round-robin pick:
- Search starts at `(last_id+1) mod REQ_NUM` and wraps; the first requester with `req_vld` set wins.
- `last_id` resets to `REQ_NUM-1`, so requester 0 wins the first tie.
- `last_id` is updated to `gnt_id` only when WAIT_DONE exits.

XFER:
- The `msg_inpt_*` outputs are a combinational mux of requester `gnt_id`.
- `req_rdy[gnt_id] = msg_inpt_rdy`; all other `req_rdy` bits are 0.
- Requests from other requesters are ignored until the FSM returns to IDLE.
- A word is transferred in each cycle where `msg_inpt_vld & msg_inpt_rdy`.
- A transfer with `msg_inpt_lst = 1` moves the FSM to WAIT_DONE.

WAIT_DONE:
- All `msg_inpt_*` outputs are 0 and all `req_rdy` are 0.
- On `hash_done`: the FSM goes to IDLE, `last_id` is set to `gnt_id`, and `done_vld`/`done_id` fire in the next cycle.

Other rules:
- A `hash_done` seen in IDLE or XFER is dropped and sets `err_spur_done`, which clears only on `rst`.
- `req_vld_byte` is forwarded unchanged. Partial masks are legal only with `lst`. The arbiter does not check this; the padding core owns it.

Reset values:
- State IDLE, `gnt_id = 0`, `last_id = REQ_NUM-1`.
- All outputs 0, including `busy`, `done_vld`, `done_id` and `err_spur_done`.

## Timing
- Grant latency: 1 cycle. A `req_vld` rising in cycle N with the FSM in IDLE is first forwarded in cycle N+1.
- Forwarding has zero latency: `msg_inpt_*` follow `req_*[gnt_id]` in the same cycle.
- Back-to-back messages: `hash_done` in cycle M puts the FSM in IDLE at M+1. With a pending request, the next XFER starts at M+2. Minimum gap between messages is 2 cycles.
- `hash_done` and `lst` in the same cycle: the FSM is in XFER, so this counts as spurious. The pipeline guarantees this cannot happen legally.
- `rst` mid-message: the FSM returns to IDLE in the next cycle and the grant is dropped. The downstream pipeline must be reset in the same cycle; the arbiter does not resynchronize it.
- Requester rule: once `req_vld` is asserted it must stay stable until accepted. The arbiter does not latch requester data.

## Structure
- Shared package `sm3_pkg`:
  - state enum `sm3_arb_st_e` with values IDLE, XFER and WAIT_DONE;
  - constant `SM3_INPT_DW`, derived from the config macro;
  - constant `SM3_INPT_BYTE_W = SM3_INPT_DW/8`.
- Sub-module `sm3_rr_pick`: combinational round-robin priority picker. Inputs are `req` and `last_id`; outputs are `any` and `pick_id`. It is reused by future multi-channel schedulers.
- Top-level logic is the FSM, the `gnt_id`/`last_id` registers, the output mux, and the `done`/`err` registers.

## Test plan
- Single requester, 64-bit: requester 2 sends `d = 64'h6162_6300_0000_0000`, `vld_byte = 8'b1110_0000`, `lst = 1`. Expect the word forwarded in cycle N+1, and after `hash_done`, `done_vld` with `done_id = 2`. Run end-to-end through the pad/expand/compress cores, the digest must equal `66c7f0f4…8f4ba8e0`.
- All four requesters assert together at reset: grants go 0, 1, 2, 3, 0. Each message is 8 words of `64'h6162_6364_6162_6364`, the last word with `lst`. Each owner's `done_id` follows in order.
- Backpressure: toggle `msg_inpt_rdy` at 50% during an 8-word message. Exactly 8 transfers must occur, `req_rdy` of non-owners stays 0, and no data is duplicated.
- Spurious completion: pulse `hash_done` in IDLE, then in XFER. Expect `err_spur_done = 1` and sticky, no state change, and no `done_vld`.
- Reset during XFER after 3 of 8 words: one cycle later, state is IDLE, all outputs are 0, and requester 0 wins the next grant.
- 32-bit build: requester 1 sends `32'h6162_6300`, `vld_byte = 4'b1110`, `lst = 1`. Expect it forwarded unchanged and `done_id = 1`.
